delta_batch_accum: RTL and testbench

- Output-side training block for the network's output layer; successor to the single-sample teacher path.
- Joins the output-neuron stream with the teacher stream and computes the per-channel error, output minus teacher.
- Averages that error over a mini-batch of 2^NB_LOG2 samples and emits one saturated WF-bit delta vector per batch to the weight-update path.
- Also counts argmax classification hits per batch and emits the count on a separate handshake channel.

---
 rtl/delta_batch_accum.sv | 164 ++++++++++++++++
 tb/tb_delta_batch_accum.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/delta_batch_accum.sv
// Output-layer training block: joins output/teacher streams, averages the error over a
// mini-batch and counts argmax hits. Define DELTA_ROUND_EN to round half up before the shift.
module delta_batch_accum #(
  parameter  int NP      = 7,
  parameter  int NC      = 6,
  parameter  int WF      = 5,
  parameter  int NB_LOG2 = 2,
  localparam int WO      = $clog2(NP) + 1 + WF,
  localparam int WA      = WO + 1 + NB_LOG2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iMode,
  input  logic                 iValid_AS_Output,
  output logic                 oReady_AS_Output,
  input  logic [NC*WO-1:0]     iData_AS_Output,
  input  logic                 iValid_AS_Teacher,
  output logic                 oReady_AS_Teacher,
  input  logic [NC*WO-1:0]     iData_AS_Teacher,
  output logic                 oValid_BM_Delta,
  input  logic                 iReady_BM_Delta,
  output logic [NC*WF-1:0]     oData_BM_Delta,
  output logic                 oValid_BM_Stat,
  input  logic                 iReady_BM_Stat,
  output logic [NB_LOG2:0]     oData_BM_Stat
);

  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [NB_LOG2:0] LP_LAST = (NB_LOG2+1)'(2**NB_LOG2 - 1);
  localparam logic signed [WA:0] LP_HALF = (WA+1)'(2**NB_LOG2 / 2);
  localparam logic signed [WA:0] LP_QMAX = (WA+1)'(2**(WF-1) - 1);
  localparam logic signed [WA:0] LP_QMIN = (WA+1)'(-(2**(WF-1)));

  typedef enum logic {ST_ACCUM, ST_EMIT} state_t;

  state_t                r_state, w_state_nxt;
  logic signed [WA-1:0]  r_acc [NC];
  logic signed [WA-1:0]  w_acc_nxt [NC];
  logic signed [WO-1:0]  w_out [NC];
  logic signed [WO-1:0]  w_tch [NC];
  logic [NB_LOG2:0]      r_cnt, r_hit, w_hit_nxt;
  logic                  r_dvld, r_svld;
  logic [NC*WF-1:0]      r_delta, w_delta_nxt;
  logic [NB_LOG2:0]      r_stat;
  logic                  w_accept, w_last, w_done, w_hit;

  // Lowest index wins on ties because only a strictly larger value replaces the best.
  function automatic logic [CW-1:0] f_argmax(input logic [NC*WO-1:0] vec);
    logic signed [WO-1:0] best, cur;
    logic [CW-1:0]        idx;
    best = vec[0 +: WO];
    idx  = '0;
    for (int c = 1; c < NC; c++) begin
      cur = vec[c*WO +: WO];
      if (cur > best) begin
        best = cur;
        idx  = CW'(c);
      end
    end
    return idx;
  endfunction

  function automatic logic [WF-1:0] f_delta(input logic signed [WA-1:0] acc);
    logic signed [WA:0] ext, q;
    ext = {acc[WA-1], acc};
`ifdef DELTA_ROUND_EN
    ext = ext + LP_HALF;
`endif
    q = ext >>> NB_LOG2;
    if (q > LP_QMAX)      return LP_QMAX[WF-1:0];
    else if (q < LP_QMIN) return LP_QMIN[WF-1:0];
    else                  return q[WF-1:0];
  endfunction

  for (genvar gc = 0; gc < NC; gc++) begin : g_unpack
    assign w_out[gc]     = iData_AS_Output[gc*WO +: WO];
    assign w_tch[gc]     = iData_AS_Teacher[gc*WO +: WO];
    assign w_acc_nxt[gc] = r_acc[gc] + WA'(w_out[gc]) - WA'(w_tch[gc]);
  end

  assign w_hit     = (f_argmax(iData_AS_Output) == f_argmax(iData_AS_Teacher));
  assign w_hit_nxt = r_hit + (NB_LOG2+1)'(w_hit);
  assign w_last    = w_accept && (r_cnt == LP_LAST);

  always_comb begin
    w_delta_nxt = '0;
    for (int c = 0; c < NC; c++) w_delta_nxt[c*WF +: WF] = f_delta(w_acc_nxt[c]);
  end

  always_comb begin
    w_state_nxt       = r_state;
    oReady_AS_Output  = 1'b0;
    oReady_AS_Teacher = 1'b0;
    w_accept          = 1'b0;
    w_done            = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (iMode) begin
          oReady_AS_Output  = iValid_AS_Teacher;
          oReady_AS_Teacher = iValid_AS_Output;
          w_accept          = iValid_AS_Output && iValid_AS_Teacher;
          if (w_accept && (r_cnt == LP_LAST)) w_state_nxt = ST_EMIT;
        end else begin
          oReady_AS_Output = 1'b1;
        end
      end
      ST_EMIT: begin
        w_done = (!r_dvld || iReady_BM_Delta) && (!r_svld || iReady_BM_Stat);
        if (w_done) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_hit   <= '0;
      r_dvld  <= 1'b0;
      r_svld  <= 1'b0;
      r_delta <= '0;
      r_stat  <= '0;
      for (int c = 0; c < NC; c++) r_acc[c] <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_ACCUM: begin
          if (!iMode) begin
            r_cnt <= '0;
            r_hit <= '0;
            for (int c = 0; c < NC; c++) r_acc[c] <= '0;
          end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            r_hit <= w_hit_nxt;
            for (int c = 0; c < NC; c++) r_acc[c] <= w_acc_nxt[c];
            if (w_last) begin
              r_delta <= w_delta_nxt;
              r_stat  <= w_hit_nxt;
              r_dvld  <= 1'b1;
              r_svld  <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (iReady_BM_Delta) r_dvld <= 1'b0;
          if (iReady_BM_Stat)  r_svld <= 1'b0;
          if (w_done) begin
            r_cnt <= '0;
            r_hit <= '0;
            for (int c = 0; c < NC; c++) r_acc[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign oValid_BM_Delta = r_dvld;
  assign oValid_BM_Stat  = r_svld;
  assign oData_BM_Delta  = r_delta;
  assign oData_BM_Stat   = r_stat;

endmodule

// File: tb/tb_delta_batch_accum.sv
// Randomized/directed bench for delta_batch_accum with an arithmetic batch model.
module tb_delta_batch_accum;
  localparam int NP = 7, NC = 6, WF = 5, NB_LOG2 = 2;
  localparam int WO = $clog2(NP) + 1 + WF;
  localparam int NB = 1 << NB_LOG2;

  logic iCLK = 0, iRST = 0, iMode = 0;
  logic iValid_AS_Output = 0, iValid_AS_Teacher = 0;
  logic oReady_AS_Output, oReady_AS_Teacher;
  logic [NC*WO-1:0] iData_AS_Output = '0, iData_AS_Teacher = '0;
  logic oValid_BM_Delta, oValid_BM_Stat;
  logic iReady_BM_Delta = 0, iReady_BM_Stat = 0;
  logic [NC*WF-1:0] oData_BM_Delta;
  logic [NB_LOG2:0] oData_BM_Stat;

  delta_batch_accum #(.NP(NP), .NC(NC), .WF(WF), .NB_LOG2(NB_LOG2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode),
    .iValid_AS_Output(iValid_AS_Output), .oReady_AS_Output(oReady_AS_Output),
    .iData_AS_Output(iData_AS_Output),
    .iValid_AS_Teacher(iValid_AS_Teacher), .oReady_AS_Teacher(oReady_AS_Teacher),
    .iData_AS_Teacher(iData_AS_Teacher),
    .oValid_BM_Delta(oValid_BM_Delta), .iReady_BM_Delta(iReady_BM_Delta),
    .oData_BM_Delta(oData_BM_Delta),
    .oValid_BM_Stat(oValid_BM_Stat), .iReady_BM_Stat(iReady_BM_Stat),
    .oData_BM_Stat(oData_BM_Stat));

  always #5 iCLK = ~iCLK;

  int n_chk = 0, n_err = 0;
  int m_sum [NC];
  int m_hit, m_cnt;
  logic [NC*WF-1:0] m_exp_d;
  logic [NB_LOG2:0] m_exp_s;
  int so [NC];
  int st [NC];

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int f_amax(input int v [NC]);
    int idx = 0;
    for (int c = 1; c < NC; c++) if (v[c] > v[idx]) idx = c;
    return idx;
  endfunction

  function automatic int f_exp_delta(input int s);
    int q;
`ifdef DELTA_ROUND_EN
    s = s + NB / 2;
`endif
    q = (s >= 0) ? s / NB : -((-s + NB - 1) / NB);
    if (q > 2**(WF-1) - 1) q = 2**(WF-1) - 1;
    if (q < -(2**(WF-1)))  q = -(2**(WF-1));
    return q;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) m_sum[c] = 0;
    m_hit = 0;
    m_cnt = 0;
  endtask

  // Presents one joined sample; called at a point just after a rising edge.
  task automatic push();
    for (int c = 0; c < NC; c++) begin
      iData_AS_Output[c*WO +: WO]  = WO'(so[c]);
      iData_AS_Teacher[c*WO +: WO] = WO'(st[c]);
    end
    iMode = 1;
    iValid_AS_Output = 1;
    iValid_AS_Teacher = 1;
    @(negedge iCLK);
    chk_eq("in_ready", {oReady_AS_Output, oReady_AS_Teacher}, 2'b11);
    @(posedge iCLK); #1;
    iValid_AS_Output = 0;
    iValid_AS_Teacher = 0;
    for (int c = 0; c < NC; c++) m_sum[c] += so[c] - st[c];
    if (f_amax(so) == f_amax(st)) m_hit++;
    m_cnt++;
    if (m_cnt == NB) begin
      for (int c = 0; c < NC; c++) m_exp_d[c*WF +: WF] = WF'(f_exp_delta(m_sum[c]));
      m_exp_s = (NB_LOG2+1)'(m_hit);
      chk_eq("dvld_rise", oValid_BM_Delta, 1);
      chk_eq("svld_rise", oValid_BM_Stat, 1);
      chk_eq("delta", oData_BM_Delta, m_exp_d);
      chk_eq("stat", oData_BM_Stat, m_exp_s);
      model_clear();
    end else begin
      chk_eq("dvld_early", oValid_BM_Delta, 0);
    end
  endtask

  task automatic drain(input int dd, input int ds);
    bit ok = 0;
    iMode = 1;
    iValid_AS_Output = 1;
    iValid_AS_Teacher = 1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      iReady_BM_Delta = (cyc >= dd);
      iReady_BM_Stat  = (cyc >= ds);
      if (oValid_BM_Delta) chk_eq("delta_hold", oData_BM_Delta, m_exp_d);
      if (oValid_BM_Stat)  chk_eq("stat_hold", oData_BM_Stat, m_exp_s);
      if (oValid_BM_Delta || oValid_BM_Stat)
        chk_eq("rdy_emit", {oReady_AS_Output, oReady_AS_Teacher}, 2'b00);
      @(posedge iCLK); #1;
      if (cyc < dd) chk_eq("dvld_hold", oValid_BM_Delta, 1);
      if (cyc >= ds) chk_eq("svld_fall", oValid_BM_Stat, 0);
      if (!oValid_BM_Delta && !oValid_BM_Stat) begin
        ok = 1;
        break;
      end
    end
    chk_eq("drain_done", ok, 1);
    chk_eq("rdy_after", {oReady_AS_Output, oReady_AS_Teacher}, 2'b11);
    iValid_AS_Output = 0;
    iValid_AS_Teacher = 0;
    iReady_BM_Delta = 0;
    iReady_BM_Stat = 0;
  endtask

  task automatic set_zero();
    for (int c = 0; c < NC; c++) begin so[c] = 0; st[c] = 0; end
  endtask

  task automatic set_rand();
    for (int c = 0; c < NC; c++) begin
      so[c] = int'($urandom_range(0, 511)) - 256;
      st[c] = int'($urandom_range(0, 511)) - 256;
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge iCLK);
    #1;
    chk_eq("rst_dvld", oValid_BM_Delta, 0);
    chk_eq("rst_svld", oValid_BM_Stat, 0);
    chk_eq("rst_ddata", oData_BM_Delta, 0);
    chk_eq("rst_sdata", oData_BM_Stat, 0);
    @(negedge iCLK) iRST = 1;
    @(posedge iCLK); #1;

    // ch0 diff +4 each sample
    for (int k = 0; k < NB; k++) begin set_zero(); so[0] = 4 + k; st[0] = k; push(); end
    drain(0, 0);

    // ch0 diffs -3,-3,-2,-2
    for (int k = 0; k < NB; k++) begin set_zero(); st[0] = (k < 2) ? 3 : 2; push(); end
    drain(0, 0);

    // ch1 saturation both ways
    for (int k = 0; k < NB; k++) begin set_zero(); so[1] = 50; st[1] = 10; push(); end
    drain(1, 0);
    for (int k = 0; k < NB; k++) begin set_zero(); so[1] = -50; st[1] = -10; push(); end
    drain(0, 2);

    // Argmax tie resolves to lowest index
    set_zero(); so[2] = 10; so[4] = 10; st[2] = 5; push();
    for (int k = 1; k < NB; k++) begin set_zero(); so[0] = 10; st[1] = 10; push(); end
    chk_eq("argmax_stat", oData_BM_Stat, 1);
    drain(5, 0);

    // Teacher valid with Output idle must not accept
    set_rand(); push();
    iMode = 1;
    iValid_AS_Teacher = 1;
    repeat (3) begin
      @(negedge iCLK);
      chk_eq("tch_only_rdy", {oReady_AS_Output, oReady_AS_Teacher}, 2'b10);
    end
    @(posedge iCLK); #1;
    iValid_AS_Teacher = 0;
    for (int k = 1; k < NB; k++) begin set_rand(); push(); end
    drain(2, 3);

    // Partial batch dropped by an inference cycle
    for (int k = 0; k < 2; k++) begin set_rand(); push(); end
    iMode = 0;
    @(negedge iCLK);
    chk_eq("inf_rdy", {oReady_AS_Output, oReady_AS_Teacher}, 2'b10);
    @(posedge iCLK); #1;
    model_clear();
    for (int k = 0; k < NB; k++) begin set_rand(); push(); end
    drain(0, 0);

    // Asynchronous reset mid-batch
    for (int k = 0; k < 2; k++) begin set_rand(); push(); end
    #2 iRST = 0;
    #1;
    chk_eq("mrst_dvld", {oValid_BM_Delta, oValid_BM_Stat}, 0);
    chk_eq("mrst_ddata", oData_BM_Delta, 0);
    chk_eq("mrst_sdata", oData_BM_Stat, 0);
    @(negedge iCLK) iRST = 1;
    @(posedge iCLK); #1;
    model_clear();
    for (int k = 0; k < NB; k++) begin set_rand(); push(); end
    drain(0, 0);

    // Random batches with random backpressure
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < NB; k++) begin set_rand(); push(); end
      drain(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
